uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 40 ++++
 rtl/uart_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: bundles the serial line, the pop/clear strobes and the receiver
// outputs so the receiver and its consumer share one connection point.
//   slave  : receiver side (uart_rx)
//   master : consumer / line driver side
// Handshake: rx_valid=1 means rd_data holds the oldest buffered byte; the
// consumer pops it by asserting rd_en for one cycle while rx_valid=1, and
// rd_en while rx_valid=0 has no effect. There is no back-pressure on the serial
// side: a byte arriving into a full buffer is dropped and flagged in overrun.
interface uart_rx_if;
  logic       uart_rx;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic [1:0] dbg_state;

  modport slave (
    input  uart_rx,
    input  rd_en,
    input  err_clr,
    output rd_data,
    output rx_valid,
    output overrun,
    output frame_err,
    output dbg_state
  );

  modport master (
    output uart_rx,
    output rd_en,
    output err_clr,
    input  rd_data,
    input  rx_valid,
    input  overrun,
    input  frame_err,
    input  dbg_state
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a small receive buffer.
// The line is brought into the clock domain by a 2-flop synchronizer. A
// falling edge starts a frame. The start bit is rechecked at mid-bit, and the
// data and stop bits are then sampled one bit period apart.
// Optional feature macro: UART_RX_FIFO_EN. When it is defined, the single
// holding register is replaced by a 4-entry FIFO.
// dbg_state exposes the FSM state: 0=IDLE 1=START 2=DATA 3=STOP.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // ---------------------------------------------------------------------------
  // Synchronizer and edge detect
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q, prev_q;
  logic rx_s;
  logic fall;

  assign rx_s = sync2_q;
  // prev_q only ever follows the synchronized line. After a low stop bit, a
  // new start therefore needs the line to go high first.
  assign fall = prev_q & ~rx_s;

  // Two-flop synchronizer plus one delayed copy for edge detection (idle high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= bus.uart_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             push;
  logic             frame_set;

  // Next-state logic. The baud counter reloads to 0 at every sample point, so
  // each bit period is timed from the previous sample and cannot drift or wrap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d   = S_START;
          bit_cnt_d = 3'd0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          // A start bit that is high again at mid-bit was a glitch.
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_s) begin
            push = 1'b1;
          end else begin
            frame_set = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, baud counter, bit counter and shift register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive buffer
  // ---------------------------------------------------------------------------
  logic       pop;
  logic       full;
  logic       accept;
  logic       overrun_set;
  logic       buf_valid;
  logic [7:0] buf_head;

  // A pop in the same cycle frees a slot, so a push into a full buffer is
  // still accepted when the consumer is reading at that moment.
  assign accept      = push & (~full | pop);
  assign overrun_set = push & full & ~pop;

`ifdef UART_RX_FIFO_EN
  logic [7:0] fifo_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q, count_d;

  assign buf_valid = (count_q != 3'd0);
  assign full      = (count_q == 3'd4);
  assign pop       = bus.rd_en & buf_valid;
  assign buf_head  = fifo_q[rd_ptr_q];
  assign count_d   = count_q + {2'b00, accept} - {2'b00, pop};

  // FIFO storage and pointers; the pointers wrap naturally modulo 4
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= 8'h00;
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (accept) begin
        fifo_q[wr_ptr_q] <= shift_q;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      count_q <= count_d;
    end
  end
`else
  logic [7:0] hold_q;
  logic       valid_q;

  assign buf_valid = valid_q;
  assign full      = valid_q;
  assign pop       = bus.rd_en & valid_q;
  assign buf_head  = hold_q;

  // Single holding register: a write refills it, a pop alone empties it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
        hold_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
  logic overrun_q, overrun_d;
  logic frame_err_q, frame_err_d;

  // If a flag is set and cleared in the same cycle, the set takes priority.
  // That keeps an error from being lost in the cycle where software clears it.
  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (bus.err_clr) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    if (overrun_set) begin
      overrun_d = 1'b1;
    end
    if (frame_set) begin
      frame_err_d = 1'b1;
    end
  end

  // Error flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.rd_data   = buf_head;
  assign bus.rx_valid  = buf_valid;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
  assign bus.dbg_state = state_q;

endmodule
